// File: rtl/mod_pipe_chain.sv
// mod_pipe_chain
//   Chain of STAGES identical WIDTH-bit processing stages with valid/ready
//   flow control. Each beat carries a 2-bit mode that travels with its data
//   and selects the per-stage operation:
//   00 pass, 01 wrapping +1, 10 invert, 11 saturating +1.
//
// Ports
//   clk      rising-edge clock
//   rst_x    asynchronous active-low reset; clears all stage state
//   i_flush  synchronous flush; empties every stage, blocks upstream
//   i_valid  upstream beat valid
//   o_ready  block accepts a beat this cycle
//   i_data   upstream data
//   i_mode   per-beat operation
//   o_valid  output beat valid (last stage occupied)
//   i_ready  downstream accepts
//   o_data   last stage data register
//   o_count  registered number of occupied stages, 0..STAGES
module mod_pipe_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_WINC = 2'b01,
    MODE_INV  = 2'b10,
    MODE_SINC = 2'b11
  } mode_e;

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [1:0]        m [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] take;
  logic [STAGES-1:0] v_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [1:0]        src_m [STAGES];

  function automatic logic [WIDTH-1:0] stage_op(input logic [1:0] md,
                                                input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    case (mode_e'(md))
      MODE_PASS: r = s;
      MODE_WINC: r = s + 1'b1;
      MODE_INV:  r = ~s;
      MODE_SINC: r = (s == '1) ? s : s + 1'b1;
      default:   r = s;
    endcase
    return r;
  endfunction

  // Stage ready chain. rdy[k] = !v[k] | rdy[k+1] is unrolled from the output
  // end with a running accumulator so the vector is never read while built.
  always_comb begin
    logic acc;
    acc         = i_ready;
    rdy         = '0;
    rdy[STAGES] = i_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc                 = acc | ~v[STAGES-1-k];
      rdy[STAGES-1-k]     = acc;
    end
  end

  assign o_ready = rdy[0] & ~i_flush;
  assign o_valid = v[STAGES-1];
  assign o_data  = d[STAGES-1];

  always_comb begin
    take     = '0;
    take[0]  = i_valid & o_ready;
    src_d[0] = i_data;
    src_m[0] = i_mode;
    for (int unsigned k = 1; k < STAGES; k++) begin
      take[k]  = v[k-1] & rdy[k];
      src_d[k] = d[k-1];
      src_m[k] = m[k-1];
    end
  end

  // A stage drains when its beat moves on (v & rdy[k+1]); a simultaneous
  // fill keeps it occupied. Flush overrides everything.
  always_comb begin
    v_nxt   = '0;
    cnt_nxt = '0;
    if (!i_flush) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_nxt[k] = take[k] | (v[k] & ~rdy[k+1]);
      end
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      cnt_nxt = cnt_nxt + CW'(v_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      v       <= '0;
      o_count <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        d[k] <= '0;
        m[k] <= '0;
      end
    end else begin
      v       <= v_nxt;
      o_count <= cnt_nxt;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (take[k]) begin
          d[k] <= stage_op(src_m[k], src_d[k]);
          m[k] <= src_m[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_pipe_chain.sv
module tb_mod_pipe_chain;

  localparam int W  = 8;
  localparam int C2 = $clog2(2 + 1);
  localparam int C3 = $clog2(3 + 1);

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  // two-stage instance
  logic          flush2 = 1'b0, valid2 = 1'b0, iready2 = 1'b0;
  logic          ready2, ovalid2;
  logic [W-1:0]  data2 = '0, odata2;
  logic [1:0]    mode2 = '0;
  logic [C2-1:0] count2;

  // three-stage instance
  logic          flush3 = 1'b0, valid3 = 1'b0, iready3 = 1'b1;
  logic          ready3, ovalid3;
  logic [W-1:0]  data3 = '0, odata3;
  logic [1:0]    mode3 = '0;
  logic [C3-1:0] count3;

  mod_pipe_chain #(.WIDTH(W), .STAGES(2)) u2 (
    .clk(clk), .rst_x(rst_x), .i_flush(flush2), .i_valid(valid2),
    .o_ready(ready2), .i_data(data2), .i_mode(mode2), .o_valid(ovalid2),
    .i_ready(iready2), .o_data(odata2), .o_count(count2)
  );

  mod_pipe_chain #(.WIDTH(W), .STAGES(3)) u3 (
    .clk(clk), .rst_x(rst_x), .i_flush(flush3), .i_valid(valid3),
    .o_ready(ready3), .i_data(data3), .i_mode(mode3), .o_valid(ovalid3),
    .i_ready(iready3), .o_data(odata3), .o_count(count3)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] q2[$];
  logic [W-1:0] q3[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expectation per consumed output beat.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_x && ovalid2 && iready2) begin
      if (q2.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out2_unexpected: got %0h expected none at %0t", odata2, $time);
      end else begin
        e = q2.pop_front();
        check("out2", 32'(odata2), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_x && ovalid3 && iready3) begin
      if (q3.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out3_unexpected: got %0h expected none at %0t", odata3, $time);
      end else begin
        e = q3.pop_front();
        check("out3", 32'(odata3), 32'(e));
      end
    end
  end

  // Offer a beat until accepted; the expectation is queued at the negedge
  // preceding the accepting edge. Returns 1 time unit after that edge.
  task automatic send2(input logic [W-1:0] dat, input logic [1:0] md, input logic [W-1:0] exp);
    logic acc;
    acc = 1'b0;
    valid2 = 1'b1; data2 = dat; mode2 = md;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (ready2) begin
        acc = 1'b1;
        q2.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    valid2 = 1'b0; data2 = 8'hEE; mode2 = 2'b10;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send2_timeout: got not-accepted expected accepted data %0h", dat);
    end
  endtask

  task automatic send3(input logic [W-1:0] dat, input logic [1:0] md, input logic [W-1:0] exp);
    logic acc;
    acc = 1'b0;
    valid3 = 1'b1; data3 = dat; mode3 = md;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      if (ready3) begin
        acc = 1'b1;
        q3.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    valid3 = 1'b0; data3 = 8'h77; mode3 = 2'b01;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send3_timeout: got not-accepted expected accepted data %0h", dat);
    end
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(ovalid2), 0);
    check("rst_data", 32'(odata2), 0);
    check("rst_count", 32'(count2), 0);
    @(negedge clk);
    rst_x = 1'b1;
    step();
    check("idle_ready2", 32'(ready2), 1);
    check("idle_ready3", 32'(ready3), 1);
    check("idle_valid3", 32'(ovalid3), 0);
    check("idle_count3", 32'(count3), 0);

    // streaming pass, two stages
    iready2 = 1'b1;
    send2(8'h10, 2'b00, 8'h10);
    check("lat_cyc1_valid", 32'(ovalid2), 0);
    send2(8'h11, 2'b00, 8'h11);
    check("lat_cyc2_valid", 32'(ovalid2), 1);
    check("lat_cyc2_data", 32'(odata2), 32'h10);
    send2(8'h12, 2'b00, 8'h12);
    check("stream_data", 32'(odata2), 32'h11);
    check("stream_count", 32'(count2), 2);
    repeat (3) step();
    check("stream_drained", 32'(count2), 0);

    // modes, three stages, back-to-back
    send3(8'hFE, 2'b01, 8'h01);
    send3(8'hFE, 2'b11, 8'hFF);
    send3(8'h5A, 2'b10, 8'hA5);
    send3(8'h5A, 2'b00, 8'h5A);
    check("modes_count", 32'(count3), 3);
    repeat (5) step();
    check("modes_drained", 32'(count3), 0);

    // backpressure
    iready2 = 1'b0;
    send2(8'hA0, 2'b00, 8'hA0);
    send2(8'hA1, 2'b00, 8'hA1);
    valid2 = 1'b1; data2 = 8'hA2; mode2 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 32'(ready2), 0);
      check("bp_count", 32'(count2), 2);
      check("bp_valid", 32'(ovalid2), 1);
      check("bp_hold", 32'(odata2), 32'hA0);
    end
    iready2 = 1'b1;
    send2(8'hA2, 2'b01, 8'hA4);
    send2(8'hA3, 2'b00, 8'hA3);
    repeat (4) step();
    check("bp_all_out", 32'(q2.size()), 0);

    // flush with a same-cycle upstream offer
    iready2 = 1'b0;
    send2(8'hB0, 2'b00, 8'hB0);
    send2(8'hB1, 2'b00, 8'hB1);
    check("fl_pre_count", 32'(count2), 2);
    flush2 = 1'b1; valid2 = 1'b1; data2 = 8'hC7; mode2 = 2'b00;
    #1;
    check("fl_ready_low", 32'(ready2), 0);
    step();
    q2.delete();
    check("fl_count", 32'(count2), 0);
    check("fl_valid", 32'(ovalid2), 0);
    flush2 = 1'b0; valid2 = 1'b0;
    #1;
    check("fl_ready_back", 32'(ready2), 1);
    iready2 = 1'b1;
    repeat (4) step();
    check("fl_no_output", 32'(count2), 0);

    // async reset mid-stream
    iready2 = 1'b0;
    send2(8'hD0, 2'b00, 8'hD0);
    send2(8'hD1, 2'b00, 8'hD1);
    check("ar_pre_valid", 32'(ovalid2), 1);
    #3;
    rst_x = 1'b0;
    #1;
    check("ar_valid", 32'(ovalid2), 0);
    check("ar_data", 32'(odata2), 0);
    check("ar_count", 32'(count2), 0);
    q2.delete();
    @(negedge clk);
    rst_x = 1'b1;
    step();
    iready2 = 1'b1;
    send2(8'h33, 2'b00, 8'h33);
    check("ar_lat1_valid", 32'(ovalid2), 0);
    step();
    check("ar_lat2_valid", 32'(ovalid2), 1);
    check("ar_lat2_data", 32'(odata2), 32'h33);
    repeat (3) step();

    check("q2_empty", 32'(q2.size()), 0);
    check("q3_empty", 32'(q3.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
